// File: rtl/uparc_pipe_ctl_pkg.sv
// Shared constants and state encoding for the pipeline sequencer.
package uparc_pipe_ctl_pkg;

  localparam int unsigned UPARC_ADDR_WIDTH = 32;
  localparam int unsigned PIPE_CNT_WIDTH   = 4;

  // Default exception vector loaded into the PC on exception entry
  localparam logic [UPARC_ADDR_WIDTH-1:0] EXC_VEC_DEFAULT = 32'h0000_0100;

  // Sequencer states; 2'd3 is unused and behaves as RUN
  typedef enum logic [1:0] {
    PIPE_RUN   = 2'd0,
    PIPE_JNULL = 2'd1,
    PIPE_FLUSH = 2'd2
  } pipe_state_e;

  // Initial flush counter value for a given flush length (length 1 -> 0)
  function automatic logic [PIPE_CNT_WIDTH-1:0] flush_cnt_init(input int unsigned cycles);
    return PIPE_CNT_WIDTH'(cycles - 1);
  endfunction

endpackage

// File: rtl/uparc_pipe_ctl.sv
// Pipeline sequencer: merges unit stalls, redirects the PC on jumps and
// exceptions, squashes wrong-path decode words and runs the exception flush.
module uparc_pipe_ctl
  import uparc_pipe_ctl_pkg::*;
#(
  parameter int unsigned                 FLUSH_CYCLES = 3,
  parameter logic [UPARC_ADDR_WIDTH-1:0] EXC_VEC      = EXC_VEC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_fetch_stall,
  input  logic                        i_exec_stall,
  input  logic                        i_mem_stall,
  input  logic                        i_jump_taken,
  input  logic [UPARC_ADDR_WIDTH-1:0] i_jump_addr,
  input  logic                        i_exc_req,
  output logic                        o_core_stall,
  output logic                        o_nullify,
  output logic                        o_pc_load,
  output logic [UPARC_ADDR_WIDTH-1:0] o_pc_addr,
  output logic                        o_exc_ack
);

  pipe_state_e                 state_q, state_d;
  logic [PIPE_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                        nullify_d, pc_load_d, exc_ack_d;
  logic [UPARC_ADDR_WIDTH-1:0] pc_addr_d;
  logic                        accept_c;

  // Stall merge is combinational so every stage sees it in the same cycle
  assign o_core_stall = i_fetch_stall | i_exec_stall | i_mem_stall;
  assign accept_c     = ~o_core_stall;

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PIPE_RUN;
      cnt_q     <= '0;
      o_nullify <= 1'b0;
      o_pc_load <= 1'b0;
      o_pc_addr <= '0;
      o_exc_ack <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_nullify <= nullify_d;
      o_pc_load <= pc_load_d;
      o_pc_addr <= pc_addr_d;
      o_exc_ack <= exc_ack_d;
    end
  end

  // Next-state and next-output decode; pulses default low so they last one cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nullify_d = o_nullify;
    pc_load_d = 1'b0;
    exc_ack_d = 1'b0;
    pc_addr_d = o_pc_addr;

    case (state_q)
      PIPE_JNULL: begin
        nullify_d = 1'b1;
        if (accept_c) begin
          if (i_exc_req) begin
            state_d   = PIPE_FLUSH;
            cnt_d     = flush_cnt_init(FLUSH_CYCLES);
            pc_load_d = 1'b1;
            pc_addr_d = EXC_VEC;
            exc_ack_d = 1'b1;
          end else begin
            // A jump here is the wrong-path word's and is dropped
            state_d   = PIPE_RUN;
            nullify_d = 1'b0;
          end
        end
      end

      PIPE_FLUSH: begin
        nullify_d = 1'b1;
        if (accept_c) begin
          if (cnt_q == '0) begin
            state_d   = PIPE_RUN;
            nullify_d = 1'b0;
          end else begin
            cnt_d = cnt_q - PIPE_CNT_WIDTH'(1);
          end
        end
      end

      default: begin
        // RUN, and the unused encoding treated as RUN
        state_d   = PIPE_RUN;
        nullify_d = 1'b0;
        if (accept_c && i_exc_req) begin
          state_d   = PIPE_FLUSH;
          cnt_d     = flush_cnt_init(FLUSH_CYCLES);
          nullify_d = 1'b1;
          pc_load_d = 1'b1;
          pc_addr_d = EXC_VEC;
          exc_ack_d = 1'b1;
        end else if (accept_c && i_jump_taken) begin
          state_d   = PIPE_JNULL;
          nullify_d = 1'b1;
          pc_load_d = 1'b1;
          pc_addr_d = i_jump_addr;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uparc_pipe_ctl.sv
// Directed bench for uparc_pipe_ctl with a queue of expected registered outputs.
module tb_uparc_pipe_ctl;

  logic        clk;
  logic        rst;
  logic        i_fetch_stall, i_exec_stall, i_mem_stall;
  logic        i_jump_taken, i_exc_req;
  logic [31:0] i_jump_addr;
  logic        o_core_stall, o_nullify, o_pc_load, o_exc_ack;
  logic [31:0] o_pc_addr;

  typedef struct packed {
    logic        pc_load;
    logic [31:0] pc_addr;
    logic        nullify;
    logic        exc_ack;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  uparc_pipe_ctl dut (
    .clk          (clk),
    .rst          (rst),
    .i_fetch_stall(i_fetch_stall),
    .i_exec_stall (i_exec_stall),
    .i_mem_stall  (i_mem_stall),
    .i_jump_taken (i_jump_taken),
    .i_jump_addr  (i_jump_addr),
    .i_exc_req    (i_exc_req),
    .o_core_stall (o_core_stall),
    .o_nullify    (o_nullify),
    .o_pc_load    (o_pc_load),
    .o_pc_addr    (o_pc_addr),
    .o_exc_ack    (o_exc_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the stall merge, queue the expected
  // registered outputs, then compare them after the edge.
  task automatic step(input string tag, input logic fs, input logic es, input logic ms,
                      input logic jt, input logic [31:0] ja, input logic ex,
                      input logic e_load, input logic [31:0] e_addr,
                      input logic e_null, input logic e_ack);
    exp_t e;
    exp_t got;
    i_fetch_stall = fs; i_exec_stall = es; i_mem_stall = ms;
    i_jump_taken  = jt; i_jump_addr  = ja; i_exc_req   = ex;
    #1;
    check({tag, ".stall"}, 32'(o_core_stall), 32'(fs | es | ms));
    e.pc_load = e_load; e.pc_addr = e_addr; e.nullify = e_null; e.exc_ack = e_ack;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({tag, ".pc_load"}, 32'(o_pc_load), 32'(got.pc_load));
    check({tag, ".pc_addr"}, o_pc_addr,      got.pc_addr);
    check({tag, ".nullify"}, 32'(o_nullify), 32'(got.nullify));
    check({tag, ".exc_ack"}, 32'(o_exc_ack), 32'(got.exc_ack));
  endtask

  initial begin
    rst = 1'b1;
    i_fetch_stall = 0; i_exec_stall = 0; i_mem_stall = 0;
    i_jump_taken = 0; i_jump_addr = '0; i_exc_req = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.nullify", 32'(o_nullify), 32'd0);
    check("rst.pc_load", 32'(o_pc_load), 32'd0);
    check("rst.pc_addr", o_pc_addr, 32'h0);
    check("rst.exc_ack", 32'(o_exc_ack), 32'd0);
    rst = 1'b0;
    step("idle0", 0,0,0, 0,32'h0,0,      0,32'h0,   0,0);

    // Taken jump: one-cycle redirect, one nullify cycle
    step("jmp",   0,0,0, 1,32'h2000,0,   1,32'h2000,1,0);
    step("jmp+1", 0,0,0, 0,32'h0,0,      0,32'h2000,0,0);
    step("jmp+2", 0,0,0, 0,32'h0,0,      0,32'h2000,0,0);

    // Exception: three nullify cycles
    step("exc",   0,0,0, 0,32'h0,1,      1,32'h100, 1,1);
    step("exc+1", 0,0,0, 0,32'h0,0,      0,32'h100, 1,0);
    step("exc+2", 0,0,0, 0,32'h0,0,      0,32'h100, 1,0);
    step("exc+3", 0,0,0, 0,32'h0,0,      0,32'h100, 0,0);

    // Exception with two stalled cycles mid-flush: five nullify cycles
    step("excs",   0,0,0, 0,32'h0,1,     1,32'h100, 1,1);
    step("excs+1", 0,0,0, 0,32'h0,0,     0,32'h100, 1,0);
    step("excs+2", 0,0,1, 0,32'h0,0,     0,32'h100, 1,0);
    step("excs+3", 0,0,1, 0,32'h0,0,     0,32'h100, 1,0);
    step("excs+4", 0,0,0, 0,32'h0,0,     0,32'h100, 1,0);
    step("excs+5", 0,0,0, 0,32'h0,0,     0,32'h100, 0,0);

    // Jumps during FLUSH are ignored
    step("fj",    0,0,0, 0,32'h0,1,      1,32'h100, 1,1);
    step("fj+1",  0,0,0, 1,32'h3000,0,   0,32'h100, 1,0);
    step("fj+2",  0,0,0, 1,32'h3000,0,   0,32'h100, 1,0);
    step("fj+3",  0,0,0, 0,32'h0,0,      0,32'h100, 0,0);

    // Jump during JNULL is wrong-path and ignored
    step("jj",    0,0,0, 1,32'h2000,0,   1,32'h2000,1,0);
    step("jj+1",  0,0,0, 1,32'h4000,0,   0,32'h2000,0,0);
    step("jj+2",  0,0,0, 0,32'h0,0,      0,32'h2000,0,0);

    // Exception on the JNULL edge is taken
    step("je",    0,0,0, 1,32'h2000,0,   1,32'h2000,1,0);
    step("je+1",  0,0,0, 0,32'h0,1,      1,32'h100, 1,1);
    step("je+2",  0,0,0, 0,32'h0,0,      0,32'h100, 1,0);
    step("je+3",  0,0,0, 0,32'h0,0,      0,32'h100, 1,0);
    step("je+4",  0,0,0, 0,32'h0,0,      0,32'h100, 0,0);

    // Same-edge exception and jump: exception wins
    step("col",   0,0,0, 1,32'h2000,1,   1,32'h100, 1,1);
    step("col+1", 0,0,0, 0,32'h0,0,      0,32'h100, 1,0);
    step("col+2", 0,0,0, 0,32'h0,0,      0,32'h100, 1,0);
    step("col+3", 0,0,0, 0,32'h0,0,      0,32'h100, 0,0);

    // Stall gating: held jump acts on the first unstalled edge
    step("sg",    0,1,0, 1,32'h5000,0,   0,32'h100, 0,0);
    step("sg+1",  0,1,0, 1,32'h5000,0,   0,32'h100, 0,0);
    step("sg+2",  0,0,0, 1,32'h5000,0,   1,32'h5000,1,0);
    step("sg+3",  0,0,0, 0,32'h0,0,      0,32'h5000,0,0);

    // Stall merge per input, and exception ignored while stalled
    step("fst",   1,0,0, 0,32'h0,1,      0,32'h5000,0,0);
    step("est",   0,1,0, 0,32'h0,0,      0,32'h5000,0,0);
    step("mst",   0,0,1, 0,32'h0,0,      0,32'h5000,0,0);
    step("nst",   0,0,0, 0,32'h0,0,      0,32'h5000,0,0);

    // Redirect pulse stays one cycle when stall rises; JNULL holds nullify while stalled
    step("ps",    0,0,0, 1,32'h6000,0,   1,32'h6000,1,0);
    step("ps+1",  1,0,0, 0,32'h0,0,      0,32'h6000,1,0);
    step("ps+2",  0,0,0, 0,32'h0,0,      0,32'h6000,0,0);

    // Reset mid-FLUSH (cnt=2) clears outputs immediately
    step("rf",    0,0,0, 0,32'h0,1,      1,32'h100, 1,1);
    #2;
    rst = 1'b1;
    #1;
    check("rf.nullify", 32'(o_nullify), 32'd0);
    check("rf.pc_load", 32'(o_pc_load), 32'd0);
    check("rf.pc_addr", o_pc_addr, 32'h0);
    check("rf.exc_ack", 32'(o_exc_ack), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rf+1",  0,0,0, 0,32'h0,0,      0,32'h0,   0,0);
    step("rf+2",  0,0,0, 1,32'h7000,0,   1,32'h7000,1,0);
    step("rf+3",  0,0,0, 0,32'h0,0,      0,32'h7000,0,0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
